// File: rtl/turret_pkg.sv
// Shared turret optical-link types and defaults, used by emitter and receiver.
package turret_pkg;

    typedef enum logic [1:0] {IDLE, BURST, COOLDOWN, CHASE} emit_state_t;

    localparam int NUM_CH_DEFAULT    = 9;
    localparam int SHOT_LEN_DEFAULT  = 90;
    localparam int CHASE_LEN_DEFAULT = 15;
    localparam int COOL_LEN_DEFAULT  = 32;

    function automatic int cnt_width(int a, int b, int c, int d);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pulse_gen.sv
// Free-running pulse pattern: PULSE_ON high cycles out of every PULSE_PERIOD.
module pulse_gen #(
    parameter int PULSE_PERIOD = 4,
    parameter int PULSE_ON     = 3
) (
    input  logic fclk,
    input  logic reset_n,
    input  logic restart,
    output logic pulse_on
);

    localparam int PW = (PULSE_PERIOD > 1) ? $clog2(PULSE_PERIOD) : 1;
    localparam logic [PW-1:0] LAST = PW'(PULSE_PERIOD - 1);
    localparam logic [PW:0]   ON_W = (PW + 1)'(PULSE_ON);

    logic [PW-1:0] phase;

    // restart is registered, so phase reads 0 in the cycle after it
    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= '0;
        end else if (restart || phase == LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign pulse_on = ({1'b0, phase} < ON_W);

endmodule

// File: rtl/shot_emitter.sv
// Turret emitter: single-shot bursts with cooldown, or framed chase emission.
// Optional SHOT_STATS_EN adds shot_count / chase_frames statistics outputs.
module shot_emitter
    import turret_pkg::*;
#(
    parameter int NUM_CH       = NUM_CH_DEFAULT,
    parameter int SHOT_LEN     = SHOT_LEN_DEFAULT,
    parameter int CHASE_LEN    = CHASE_LEN_DEFAULT,
    parameter int COOL_LEN     = COOL_LEN_DEFAULT,
    parameter int PULSE_PERIOD = 4,
    parameter int PULSE_ON     = 3
) (
    input  logic              fclk,
    input  logic              reset_n,
    input  logic              fire,
    input  logic              sw_chase,
    input  logic [NUM_CH-1:0] aim_mask,
    output logic [NUM_CH-1:0] emit,
    output logic              busy,
    output logic              done
`ifdef SHOT_STATS_EN
    ,
    output logic [7:0]        shot_count,
    output logic [7:0]        chase_frames
`endif
);

    localparam int CW = cnt_width(SHOT_LEN, COOL_LEN, CHASE_LEN, PULSE_PERIOD);
    localparam logic [CW-1:0] SHOT_LAST  = CW'(SHOT_LEN - 1);
    localparam logic [CW-1:0] COOL_LAST  = CW'(COOL_LEN - 1);
    localparam logic [CW-1:0] CHASE_LAST = CW'(CHASE_LEN - 1);

    emit_state_t       state, nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [CW-1:0]     fcnt, fcnt_nxt;
    logic [NUM_CH-1:0] shot_mask, mask_nxt, cur_mask;
    logic              frame_start, done_nxt, restart, pulse_on, active;

    always_comb begin
        nxt         = state;
        cnt_nxt     = '0;
        fcnt_nxt    = '0;
        mask_nxt    = shot_mask;
        done_nxt    = 1'b0;
        frame_start = (state == CHASE) && (fcnt == '0);
        // a chase frame uses the aim sampled in its first cycle
        cur_mask    = frame_start ? aim_mask : shot_mask;
        unique case (state)
            IDLE: begin
                if (sw_chase) begin
                    nxt = CHASE;
                end else if (fire) begin
                    nxt      = BURST;
                    mask_nxt = aim_mask;
                end
            end
            BURST: begin
                if (sw_chase) begin
                    nxt = CHASE;
                end else if (cnt == SHOT_LAST) begin
                    nxt      = COOLDOWN;
                    done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            COOLDOWN: begin
                if (sw_chase) begin
                    nxt = CHASE;
                end else if (cnt == COOL_LAST) begin
                    nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CHASE: begin
                mask_nxt = cur_mask;
                if (!sw_chase) begin
                    nxt = IDLE;
                end else if (fcnt != CHASE_LAST) begin
                    fcnt_nxt = fcnt + 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
        restart = (nxt == BURST && state != BURST)
                || (nxt == CHASE && fcnt_nxt == '0);
        active  = (state == BURST) || (state == CHASE);
    end

    pulse_gen #(
        .PULSE_PERIOD(PULSE_PERIOD),
        .PULSE_ON    (PULSE_ON)
    ) u_pulse (
        .fclk    (fclk),
        .reset_n (reset_n),
        .restart (restart),
        .pulse_on(pulse_on)
    );

    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            fcnt      <= '0;
            shot_mask <= '0;
            emit      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_nxt;
            fcnt      <= fcnt_nxt;
            shot_mask <= mask_nxt;
            emit      <= active ? (cur_mask & {NUM_CH{pulse_on}}) : '0;
            busy      <= (state == BURST) || (state == COOLDOWN);
            done      <= done_nxt;
        end
    end

`ifdef SHOT_STATS_EN
    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            shot_count   <= '0;
            chase_frames <= '0;
        end else begin
            if (done_nxt && shot_count != 8'hFF) begin
                shot_count <= shot_count + 1'b1;
            end
            if (state != CHASE && nxt == CHASE) begin
                chase_frames <= '0;
            end else if (frame_start && chase_frames != 8'hFF) begin
                chase_frames <= chase_frames + 1'b1;
            end
        end
    end
`endif

endmodule
